// File: rtl/add_pipe_pkg.sv
// rtl/add_pipe_pkg.sv - elaboration helpers for the segmented pipelined adder
//
// Purpose: shared compile-time helpers for add_pipe_cla.
//   seg_width  : bits per pipeline segment (WIDTH / SEGS)
//   seg_cfg_ok : true when SEGS is in 1..WIDTH and divides WIDTH exactly
package add_pipe_pkg;

  function automatic int seg_width(input int width, input int segs);
    return (segs > 0) ? (width / segs) : width;
  endfunction

  function automatic bit seg_cfg_ok(input int width, input int segs);
    return (segs >= 1) && (segs <= width) && ((width % segs) == 0);
  endfunction

endpackage

// File: rtl/add_pipe_cla_seg.sv
// rtl/add_pipe_cla_seg.sv - combinational W-bit carry-lookahead adder segment
//
// Purpose: one segment of the pipelined adder; s = a + b + ci, co = carry out.
// Ports:
//   a, b : W-bit operands
//   ci   : carry in
//   s    : W-bit sum
//   co   : carry out of bit W-1
module cla_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;
  logic         run;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat sum of products: c[i] = ci&p[0..i-1] | OR_j g[j]&p[j+1..i-1].
  // No carry depends on a lower computed carry, so the depth stays two-level.
  always_comb begin
    c   = '0;
    run = 1'b0;
    for (int i = 0; i <= W; i++) begin
      run = ci;
      for (int j = 0; j < i; j++) begin
        run = run & p[j];
      end
      c[i] = run;
      for (int j = 0; j < i; j++) begin
        run = g[j];
        for (int m = j + 1; m < i; m++) begin
          run = run & p[m];
        end
        c[i] = c[i] | run;
      end
    end
  end

  assign s  = p ^ c[W-1:0];
  assign co = c[W];

endmodule

// File: rtl/add_pipe_cla.sv
// rtl/add_pipe_cla.sv - segmented, pipelined carry-lookahead adder/subtractor
//
// Purpose: WIDTH-bit a +/- b split into SEGS CLA segments, one register stage
// per segment, carry handed from stage to stage. Operands are skewed on entry
// and sums deskewed on exit, so results leave word-aligned after SEGS cycles.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand beat handshake
//   a, b, cin, sub       : operands, carry-in (add only), 0=add 1=subtract
//   out_valid / out_ready: result beat handshake
//   sum, cout, ovf       : result, carry out (sub: 1 = no borrow), signed overflow
module add_pipe_cla
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW   = seg_width(WIDTH, SEGS);
  localparam int LAST = SEGS - 1;

  if (!seg_cfg_ok(WIDTH, SEGS)) begin : g_bad_cfg
    $error("add_pipe_cla: SEGS must be in 1..WIDTH and divide WIDTH");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtract is a + ~b + 1; the forced carry-in makes cin irrelevant then.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  // The whole pipe moves as one; no bubble squeezing, so a single enable suffices.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  genvar k;
  for (k = 0; k < SEGS; k++) begin : g_stage
    // Stage k still carries the operand bits of segments k+1..LAST (skew)
    // and the finished sum bits of segments 0..k (deskew).
    localparam int REM   = SEGS - 1 - k;
    localparam int SRC_W = (REM + 1) * SW;
    localparam int SUM_W = (k + 1) * SW;

    logic [SRC_W-1:0] a_src;
    logic [SRC_W-1:0] b_src;
    logic             c_src;
    logic             v_src;
    logic             am_src;
    logic             bm_src;
    logic [SW-1:0]    seg_s;
    logic             seg_co;
    logic [SUM_W-1:0] s_nxt;

    logic             v_q;
    logic             c_q;
    logic             am_q;
    logic             bm_q;
    logic [SUM_W-1:0] s_q;

    if (k == 0) begin : g_src
      assign a_src  = a;
      assign b_src  = b_eff;
      assign c_src  = c0;
      assign v_src  = in_valid;
      assign am_src = a[WIDTH-1];
      assign bm_src = b_eff[WIDTH-1];
      assign s_nxt  = seg_s;
    end else begin : g_src
      assign a_src  = g_stage[k-1].g_rem.a_q;
      assign b_src  = g_stage[k-1].g_rem.b_q;
      assign c_src  = g_stage[k-1].c_q;
      assign v_src  = g_stage[k-1].v_q;
      assign am_src = g_stage[k-1].am_q;
      assign bm_src = g_stage[k-1].bm_q;
      assign s_nxt  = {seg_s, g_stage[k-1].s_q};
    end

    cla_seg #(.W(SW)) u_cla (
      .a  (a_src[SW-1:0]),
      .b  (b_src[SW-1:0]),
      .ci (c_src),
      .s  (seg_s),
      .co (seg_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        am_q <= 1'b0;
        bm_q <= 1'b0;
        s_q  <= '0;
      end else if (advance) begin
        v_q  <= v_src;
        c_q  <= seg_co;
        am_q <= am_src;
        bm_q <= bm_src;
        s_q  <= s_nxt;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM*SW-1:0] a_q;
      logic [REM*SW-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_src[SRC_W-1:SW];
          b_q <= b_src[SRC_W-1:SW];
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign sum       = g_stage[LAST].s_q;
  assign cout      = g_stage[LAST].c_q;
  // Overflow: like-signed operands producing a result of the other sign.
  assign ovf       = (g_stage[LAST].am_q == g_stage[LAST].bm_q) &&
                     (sum[WIDTH-1] != g_stage[LAST].am_q);

endmodule

// File: tb/tb_add_pipe_cla.sv
// tb/tb_add_pipe_cla.sv - directed self-checking bench for add_pipe_cla
module tb_add_pipe_cla;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;

  logic        in_ready,  out_valid,  cout,  ovf;
  logic [15:0] sum;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [15:0] sum1;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q16[$];

  logic [15:0] op_a[16];
  logic [15:0] op_b[16];
  logic        op_cin[16];
  logic        op_sub[16];
  logic [15:0] ex_s[16];
  logic        ex_c[16];
  logic        ex_o[16];

  add_pipe_cla #(.WIDTH(16), .SEGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  add_pipe_cla #(.WIDTH(16), .SEGS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid1), .out_ready(1'b1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  add_pipe_cla #(.WIDTH(16), .SEGS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid16), .out_ready(1'b1),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic sb);
    logic [15:0] ye;
    logic [16:0] r;
    logic        c0;
    ye = sb ? ~y : y;
    c0 = sb ? 1'b1 : ci;
    r  = {1'b0, x} + {1'b0, ye} + {16'b0, c0};
    return {(x[15] == ye[15]) && (r[15] != x[15]), r[16], r[15:0]};
  endfunction

  task automatic set_beat(input int i, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic eo);
    op_a[i] = x; op_b[i] = y; op_cin[i] = ci; op_sub[i] = sb;
    ex_s[i] = es; ex_c[i] = ec; ex_o[i] = eo;
  endtask

  task automatic set_rand(input int i);
    logic [17:0] r;
    op_a[i]   = 16'($urandom);
    op_b[i]   = 16'($urandom);
    op_cin[i] = 1'($urandom);
    op_sub[i] = 1'($urandom);
    r = ref_op(op_a[i], op_b[i], op_cin[i], op_sub[i]);
    ex_s[i] = r[15:0]; ex_c[i] = r[16]; ex_o[i] = r[17];
  endtask

  // Streams n beats from the op_* tables; out_ready low for cycles
  // [stall_from, stall_from+stall_len). Entered and left at posedge+1.
  task automatic run_stream(input string name, input int n, input int stall_from,
                            input int stall_len, input int exp_stalls);
    int   sent, got, stalls, first, last;
    logic took;
    sent = 0; got = 0; stalls = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 100 && got < n; cyc++) begin
      out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      in_valid  = (sent < n);
      if (sent < n) begin
        a = op_a[sent]; b = op_b[sent]; cin = op_cin[sent]; sub = op_sub[sent];
      end
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("%s_sum[%0d]", name, got),  sum,  ex_s[got]);
        chk($sformatf("%s_cout[%0d]", name, got), cout, ex_c[got]);
        chk($sformatf("%s_ovf[%0d]", name, got),  ovf,  ex_o[got]);
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end else if (out_valid && !out_ready) begin
        stalls++;
        chk($sformatf("%s_stall_in_ready", name), in_ready, 1'b0);
        chk($sformatf("%s_stall_hold", name), sum, ex_s[got]);
      end
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk($sformatf("%s_sent", name), sent, n);
    chk($sformatf("%s_received", name), got, n);
    chk($sformatf("%s_stalls", name), stalls, exp_stalls);
    if (exp_stalls == 0) begin
      chk($sformatf("%s_latency", name), first, 4);
      chk($sformatf("%s_back_to_back", name), last - first, n - 1);
    end
  endtask

  // Scoreboards for the SEGS=1 and SEGS=16 instances (always ready downstream).
  always @(posedge clk) begin
    exp_t        e;
    logic [17:0] r;
    if (rst_n && in_valid) begin
      r = ref_op(a, b, cin, sub);
      e.s = r[15:0]; e.c = r[16]; e.o = r[17];
      e.due = cyc_cnt + 1;
      q1.push_back(e);
      e.due = cyc_cnt + 16;
      q16.push_back(e);
    end
    cyc_cnt++;
  end

  always @(negedge rst_n) begin
    q1.delete();
    q16.delete();
  end

  always @(negedge clk) begin
    exp_t e;
    chk("seg1_in_ready", in_ready1, 1'b1);
    chk("seg16_in_ready", in_ready16, 1'b1);
    if (out_valid1) begin
      if (q1.size() == 0) begin
        chk("seg1_unexpected_valid", q1.size(), 1);
      end else begin
        e = q1.pop_front();
        chk("seg1_sum", sum1, e.s);
        chk("seg1_cout", cout1, e.c);
        chk("seg1_ovf", ovf1, e.o);
        chk("seg1_latency", cyc_cnt, e.due);
      end
    end
    if (out_valid16) begin
      if (q16.size() == 0) begin
        chk("seg16_unexpected_valid", q16.size(), 1);
      end else begin
        e = q16.pop_front();
        chk("seg16_sum", sum16, e.s);
        chk("seg16_cout", cout16, e.c);
        chk("seg16_ovf", ovf16, e.o);
        chk("seg16_latency", cyc_cnt, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    @(posedge clk); #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_sum", sum, 16'h0000);
    chk("reset_cout", cout, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    set_beat(0, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_stream("add_wrap", 1, 0, 0, 0);
    set_beat(0, 16'hCCCC, 16'hC564, 1'b0, 1'b0, 16'h9230, 1'b1, 1'b0);
    run_stream("add_cccc", 1, 0, 0, 0);
    set_beat(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_stream("carry_chain", 1, 0, 0, 0);
    set_beat(0, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_stream("sub_ovf", 1, 0, 0, 0);

    for (int i = 0; i < 8; i++) set_rand(i);
    run_stream("random", 8, 0, 0, 0);

    for (int i = 0; i < 8; i++) set_rand(i);
    run_stream("stall", 8, 0, 7, 3);

    // Mid-cycle reset with results in flight and one at the output.
    for (int i = 0; i < 4; i++) set_rand(i);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = op_a[i]; b = op_b[i]; cin = op_cin[i]; sub = op_sub[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", out_valid, 1'b0);
    chk("async_reset_sum", sum, 16'h0000);
    chk("async_reset_cout", cout, 1'b0);
    chk("async_reset_ovf", ovf, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk("post_reset_no_stale", out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Subtract ignores cin: 5 - 3 = 2, no borrow.
    set_beat(0, 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_stream("sub_cin_ignored", 1, 0, 0, 0);

    repeat (20) @(posedge clk);
    #1;
    chk("seg1_drained", q1.size(), 0);
    chk("seg16_drained", q16.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
